// File: rtl/alu_regfile.sv
`timescale 1ns/1ps
// alu_regfile: execution core of the 8-bit single-cycle CPU.
// An 8 x 8-bit register file (two combinational read ports, one clocked
// write port) feeds an operand-2 selector (register, negated register or
// immediate) and a small ALU. The ALU result is the write-back data, and
// ZERO flags a zero result for the branch unit.
// Optional feature macro: ALU_MUL_EN adds an unsigned MUL on ALUOP 100.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WRITEENABLE,
    input  logic [ADDR_W-1:0] WRITEADDR,
    input  logic [ADDR_W-1:0] READADDR1,
    input  logic [ADDR_W-1:0] READADDR2,
    input  logic [DATA_W-1:0] IMMEDIATE,
    input  logic              NEG_SEL,
    input  logic              IMM_SEL,
    input  logic [2:0]        ALUOP,
    output logic [DATA_W-1:0] REGOUT1,
    output logic [DATA_W-1:0] REGOUT2,
    output logic [DATA_W-1:0] ALURESULT,
    output logic              ZERO
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    localparam logic [2:0] OP_FORWARD = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_OR      = 3'b011;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL     = 3'b100;
`endif

    // Current contents of every register, gathered for the read muxes.
    logic [DATA_W-1:0] reg_q [NUM_REGS];

    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] neg_op2;
    logic [DATA_W-1:0] alu_result;

    // One flop bank per register. Reset clears asynchronously, so a write
    // that was about to land when reset rose is simply lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] value_reg;
            logic              write_hit;

            assign write_hit = WRITEENABLE && (WRITEADDR == ADDR_W'(gi));

            // Load the ALU result when this register is the write target.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    value_reg <= '0;
                end else if (write_hit) begin
                    value_reg <= alu_result;
                end
            end

            assign reg_q[gi] = value_reg;
        end
    endgenerate

    // Read ports are plain muxes: no latency and no write bypass, so a
    // register that is both source and destination supplies its old value.
    assign REGOUT1 = reg_q[READADDR1];
    assign REGOUT2 = reg_q[READADDR2];

    // Two's-complement negation; 0x00 and 0x80 map onto themselves.
    assign neg_op2 = ~REGOUT2 + DATA_W'(1);

    // Operand 2 select: the immediate wins over negation.
    always_comb begin
        op2 = REGOUT2;
        if (IMM_SEL) begin
            op2 = IMMEDIATE;
        end else if (NEG_SEL) begin
            op2 = neg_op2;
        end
    end

`ifdef ALU_MUL_EN
    logic [DATA_W-1:0] mul_lo;
    // Only the low half of the product is ever used.
    assign mul_lo = REGOUT1 * op2;
`endif

    // ALU function select; unused opcodes yield zero so ZERO reads 1.
    always_comb begin
        alu_result = '0;
        case (ALUOP)
            OP_FORWARD: alu_result = op2;
            OP_ADD:     alu_result = REGOUT1 + op2;
            OP_AND:     alu_result = REGOUT1 & op2;
            OP_OR:      alu_result = REGOUT1 | op2;
`ifdef ALU_MUL_EN
            OP_MUL:     alu_result = mul_lo;
`endif
            default:    alu_result = '0;
        endcase
    end

    assign ALURESULT = alu_result;
    assign ZERO      = (alu_result == '0);

endmodule

// File: tb/tb_alu_regfile.sv
`timescale 1ns/1ps
// Self-checking bench for alu_regfile: directed cases from the CPU's
// instruction usage plus randomized traffic against an arithmetic model.
module tb_alu_regfile;

    logic       CLK;
    logic       RESET;
    logic       WRITEENABLE;
    logic [2:0] WRITEADDR;
    logic [2:0] READADDR1;
    logic [2:0] READADDR2;
    logic [7:0] IMMEDIATE;
    logic       NEG_SEL;
    logic       IMM_SEL;
    logic [2:0] ALUOP;
    logic [7:0] REGOUT1;
    logic [7:0] REGOUT2;
    logic [7:0] ALURESULT;
    logic       ZERO;

    int n_checks = 0;
    int n_pass   = 0;
    int model [8];

    alu_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WRITEENABLE (WRITEENABLE),
        .WRITEADDR   (WRITEADDR),
        .READADDR1   (READADDR1),
        .READADDR2   (READADDR2),
        .IMMEDIATE   (IMMEDIATE),
        .NEG_SEL     (NEG_SEL),
        .IMM_SEL     (IMM_SEL),
        .ALUOP       (ALUOP),
        .REGOUT1     (REGOUT1),
        .REGOUT2     (REGOUT2),
        .ALURESULT   (ALURESULT),
        .ZERO        (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU written from the instruction rules with integer arithmetic.
    function automatic int model_alu(input int op, input int a, input int b,
                                     input int imm, input bit neg, input bit isel);
        int o2;
        int r;
        if (isel)      o2 = imm;
        else if (neg)  o2 = (256 - b) % 256;
        else           o2 = b;
        case (op)
            0:       r = o2;
            1:       r = (a + o2) % 256;
            2:       r = a & o2;
            3:       r = a | o2;
`ifdef ALU_MUL_EN
            4:       r = (a * o2) % 256;
`endif
            default: r = 0;
        endcase
        return r;
    endfunction

    // One transaction: drive inputs after a falling edge, check, then clock.
    // want >= 0 adds a check of ALURESULT against a hand-derived constant.
    task automatic tx(input string tag, input bit we, input int wa, input int ra1,
                      input int ra2, input int imm, input bit neg, input bit isel,
                      input int op, input int want);
        int exp;
        WRITEENABLE = we;
        WRITEADDR   = 3'(wa);
        READADDR1   = 3'(ra1);
        READADDR2   = 3'(ra2);
        IMMEDIATE   = 8'(imm);
        NEG_SEL     = neg;
        IMM_SEL     = isel;
        ALUOP       = 3'(op);
        #1;
        exp = model_alu(op, model[ra1], model[ra2], imm, neg, isel);
        check({tag, ".regout1"}, 32'(REGOUT1), 32'(model[ra1]));
        check({tag, ".regout2"}, 32'(REGOUT2), 32'(model[ra2]));
        check({tag, ".result"}, 32'(ALURESULT), 32'(exp));
        check({tag, ".zero"}, 32'(ZERO), 32'(exp == 0));
        if (want >= 0) check({tag, ".want"}, 32'(ALURESULT), 32'(want));
        $display("txn %-10s we=%0d wa=%0d ra1=%0d ra2=%0d imm=%02h neg=%0d isel=%0d op=%0d -> res=%02h z=%0d",
                 tag, we, wa, ra1, ra2, imm, neg, isel, op, ALURESULT, ZERO);
        @(posedge CLK);
        if (we && !RESET) model[wa] = exp;
        @(negedge CLK);
    endtask

    // Sweep both read ports over all registers without clocking.
    task automatic read_all(input string tag, input bit expect_zero);
        WRITEENABLE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            READADDR1 = 3'(i);
            READADDR2 = 3'(7 - i);
            #1;
            check($sformatf("%s.r1[%0d]", tag, i), 32'(REGOUT1),
                  expect_zero ? 32'd0 : 32'(model[i]));
            check($sformatf("%s.r2[%0d]", tag, 7 - i), 32'(REGOUT2),
                  expect_zero ? 32'd0 : 32'(model[7 - i]));
        end
        $display("txn %-10s read sweep of all registers", tag);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 0;
        RESET = 1'b0; WRITEENABLE = 1'b0; WRITEADDR = '0; READADDR1 = '0;
        READADDR2 = '0; IMMEDIATE = '0; NEG_SEL = 1'b0; IMM_SEL = 1'b0; ALUOP = '0;

        // Reset raised between edges; writes must be ignored while it is held.
        #2 RESET = 1'b1;
        @(negedge CLK);
        read_all("rst_read", 1'b1);
        tx("rst_write", 1, 3, 3, 3, 8'h55, 0, 1, 0, 8'h55);
        read_all("rst_after", 1'b1);
        RESET = 1'b0;

        // LOADI
        tx("loadi4", 1, 4, 0, 0, 8'h05, 0, 1, 0, 8'h05);
        tx("loadi2", 1, 2, 4, 2, 8'h03, 0, 1, 0, 8'h03);
        // ADD / SUB / SUB with write-back
        tx("add", 0, 0, 4, 2, 0, 0, 0, 1, 8'h08);
        tx("sub", 0, 0, 4, 2, 0, 1, 0, 1, 8'h02);
        tx("sub_wb", 1, 6, 4, 2, 0, 1, 0, 1, 8'h02);
        tx("mov6", 0, 0, 0, 6, 0, 0, 0, 0, 8'h02);
        // BEQ with equal operands: ZERO set, nothing written
        tx("ld1_2a", 1, 1, 0, 0, 8'h2A, 0, 1, 0, 8'h2A);
        tx("ld2_2a", 1, 2, 0, 0, 8'h2A, 0, 1, 0, 8'h2A);
        tx("beq", 0, 5, 1, 2, 0, 1, 0, 1, 8'h00);
        read_all("beq_after", 1'b0);
        // Logic and forward
        tx("ld1_f0", 1, 1, 0, 0, 8'hF0, 0, 1, 0, 8'hF0);
        tx("ld2_3c", 1, 2, 0, 0, 8'h3C, 0, 1, 0, 8'h3C);
        tx("and", 0, 0, 1, 2, 0, 0, 0, 2, 8'h30);
        tx("or", 0, 0, 1, 2, 0, 0, 0, 3, 8'hFC);
        tx("mov", 0, 0, 1, 2, 0, 0, 0, 0, 8'h3C);
        // Wrap-around add
        tx("ld3_ff", 1, 3, 0, 0, 8'hFF, 0, 1, 0, 8'hFF);
        tx("ld5_01", 1, 5, 0, 0, 8'h01, 0, 1, 0, 8'h01);
        tx("add_wrap", 0, 0, 3, 5, 0, 0, 0, 1, 8'h00);
        // Negation boundaries
        tx("ld0_00", 1, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00);
        tx("ld7_80", 1, 7, 0, 0, 8'h80, 0, 1, 0, 8'h80);
        tx("neg00", 0, 0, 0, 0, 0, 1, 0, 0, 8'h00);
        tx("neg80", 0, 0, 0, 7, 0, 1, 0, 0, 8'h80);
        // Destination equals source: pre-edge value is the operand
        tx("self_add", 1, 4, 4, 4, 0, 0, 0, 1, 8'h0A);
        tx("self_rd", 0, 0, 4, 4, 0, 0, 0, 0, 8'h0A);
        // Reserved opcodes, and the optional multiplier slot
        tx("rsv111", 0, 0, 1, 2, 8'h11, 0, 0, 7, 8'h00);
        tx("ld1_10", 1, 1, 0, 0, 8'h10, 0, 1, 0, 8'h10);
`ifdef ALU_MUL_EN
        tx("mul", 0, 0, 1, 0, 8'h11, 0, 1, 4, 8'h10);
`else
        tx("rsv100", 0, 0, 1, 0, 8'h11, 0, 1, 4, 8'h00);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            tx("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               $urandom_range(0, 7), -1);
        end

        // Reset in mid-cycle with a write pending: clears at once, write lost
        tx("ld4_a5", 1, 4, 0, 0, 8'hA5, 0, 1, 0, 8'hA5);
        WRITEENABLE = 1'b1; WRITEADDR = 3'd4; READADDR1 = 3'd4; READADDR2 = 3'd4;
        IMMEDIATE = 8'h99; IMM_SEL = 1'b1; NEG_SEL = 1'b0; ALUOP = 3'd0;
        #1;
        check("pre_rst.r1", 32'(REGOUT1), 32'hA5);
        #1 RESET = 1'b1;
        #1;
        check("mid_rst.r1", 32'(REGOUT1), 32'h00);
        check("mid_rst.result", 32'(ALURESULT), 32'h99);
        $display("txn %-10s reset asserted between edges with write pending", "mid_rst");
        @(posedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 8; i++) model[i] = 0;
        RESET = 1'b0;
        read_all("post_rst", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Execution core of the 8-bit single-cycle CPU.
- Contains an 8-entry x 8-bit register file with two combinational read ports and one clocked write port.
- The register file feeds the operand-2 select logic (negate, immediate) and a 4-function ALU, whose result is written back to the register file.
- Produces the ZERO flag consumed by the CPU's branch/flow-control unit.

Parameters:
- DATA_W, 8, datapath/register width in bits.
- ADDR_W, 3, register address width; number of registers = 2**ADDR_W (8).

Ports:
- CLK  input  1  clock; register writes occur on its rising edge.
- RESET  input  1  asynchronous, active-high reset; clears all registers.
- WRITEENABLE  input  1  1 = write ALURESULT to register WRITEADDR at the next rising CLK.
- WRITEADDR  input  ADDR_W  destination register index.
- READADDR1  input  ADDR_W  source register for REGOUT1 / ALU operand 1.
- READADDR2  input  ADDR_W  source register for REGOUT2.
- IMMEDIATE  input  DATA_W  immediate operand.
- NEG_SEL  input  1  1 = operand 2 base value is two's-complement negation of REGOUT2 (SUB/BEQ).
- IMM_SEL  input  1  1 = operand 2 is IMMEDIATE; overrides NEG_SEL.
- ALUOP  input  3  ALU function select.
- REGOUT1  output  DATA_W  contents of register READADDR1.
- REGOUT2  output  DATA_W  contents of register READADDR2.
- ALURESULT  output  DATA_W  ALU result; this is also the write-back data.
- ZERO  output  1  1 when ALURESULT == 0.

Behaviour:
- Clocking and reset: one clock (CLK); reset is asynchronous and active-high (RESET).
- While RESET = 1:
  - All 8 registers read 0.
  - Writes are suppressed.
  - Outputs track the combinational logic with all-zero register contents.
- Register file reads:
  - REGOUT1 and REGOUT2 are purely combinational, with zero-cycle latency from the address or the stored value.
  - Reading the same register on both ports is legal.
- Register file write:
  - On a CLK rising edge with RESET = 0 and WRITEENABLE = 1, reg[WRITEADDR] <= ALURESULT.
  - Every other register holds its value.
  - The new value is visible on the read ports after the edge; there is no same-cycle bypass.
- Operand 2:
  - If IMM_SEL = 1, OP2 = IMMEDIATE.
  - Otherwise, if NEG_SEL = 1, OP2 = (~REGOUT2 + 1) mod 2**DATA_W.
  - Otherwise, OP2 = REGOUT2.
  - Operand 1 is always REGOUT1.
- ALU functions (combinational, result truncated to DATA_W bits, no carry or overflow output):
  - 000 FORWARD: result = OP2.
  - 001 ADD: result = REGOUT1 + OP2, wraps mod 256.
  - 010 AND: bitwise AND of REGOUT1 and OP2.
  - 011 OR: bitwise OR of REGOUT1 and OP2.
  - 100-111 reserved: result = 0, so ZERO = 1 (unless ALU_MUL_EN is defined; see below).
- ZERO flag: combinational, ZERO = (ALURESULT == 0), valid for every ALUOP.
- Instruction mapping used by the CPU control unit:
  - LOADI: 000, IMM_SEL = 1.
  - MOV: 000.
  - ADD: 001.
  - SUB: 001, NEG_SEL = 1.
  - AND: 010.
  - OR: 011.
  - BEQ: 001, NEG_SEL = 1, WRITEENABLE = 0; ZERO = 1 means the operands are equal.
- Boundary cases:
  - Negation of 0x00 = 0x00.
  - Negation of 0x80 = 0x80.
  - ADD 0xFF + 0x01 = 0x00 with ZERO = 1.
  - A write whose destination is also a source uses the pre-edge value as the operand.
  - RESET asserted mid-cycle clears immediately; a write pending at that point is lost.

Optional Feature:
- Macro: ALU_MUL_EN.
- When defined, ALUOP 100 = MUL, result = low 8 bits of REGOUT1 * OP2 (unsigned); 101-111 remain reserved (result 0).
- When undefined, 100 is reserved like 101-111, and no multiplier hardware is present.

Test Plan:
- Assert RESET asynchronously (between edges), read all 8 registers -> every REGOUT = 0x00; a write attempted with RESET = 1 has no effect.
- LOADI: IMM_SEL = 1, ALUOP = 000, IMMEDIATE = 0x05, WRITEADDR = 4, clock edge -> reg4 = 0x05; repeat with 0x03 into reg2.
- ADD and SUB (with reg4 = 5, reg2 = 3):
  - READADDR1 = 4, READADDR2 = 2, ALUOP = 001 -> ALURESULT = 0x08, ZERO = 0.
  - NEG_SEL = 1 -> ALURESULT = 0x02.
  - Write to reg6 -> reg6 = 0x02.
- BEQ with equal operands: reg1 = reg2 = 0x2A, NEG_SEL = 1, ALUOP = 001, WRITEENABLE = 0 -> ZERO = 1, no register changes after the edge.
- Logic and forward: reg1 = 0xF0, reg2 = 0x3C:
  - AND -> 0x30.
  - OR -> 0xFC.
  - MOV (ALUOP = 000) -> 0x3C.
  - ADD 0xFF + 0x01 -> 0x00, ZERO = 1.
- Reserved ALUOP 111 -> ALURESULT = 0x00, ZERO = 1. With ALU_MUL_EN defined: ALUOP 100, 0x10 * 0x11 -> 0x10.
